// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lamp_pkg
// Description : Shared lamp link constants, FSM state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lamp_pkg;

   localparam int unsigned c_lamp_freq     = 20_000_000;
   localparam int unsigned c_lamp_dck_freq = 100_000;
   localparam int unsigned c_lamp_bits     = 128;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } lamp_state_t;

   function automatic int unsigned lamp_half_period(input int unsigned freq,
                                                    input int unsigned dck_freq);
      return freq / (2 * dck_freq);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dck_divider.sv
`default_nettype none
// ============================================================================
// Module      : dck_divider
// Description : Loadable down-counter; o_tick is high in the last of N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dck_divider #(
   parameter int unsigned c_width = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [c_width-1:0] i_count,
   output logic               o_tick
);

   logic [c_width-1:0] cnt_q;
   logic [c_width-1:0] cnt_d;

   // Saturates at zero so an idle divider never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_count - c_width'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - c_width'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_tx
// Description : Fixed-length MSB-first SPI frame transmitter with CS framing.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_tx
   import lamp_pkg::*;
#(
   parameter int unsigned c_freq     = c_lamp_freq,
   parameter int unsigned c_dck_freq = c_lamp_dck_freq,
   parameter int unsigned c_bits     = c_lamp_bits
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [c_bits-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_done,
   output logic              o_cs,
   output logic              o_dck,
   output logic              o_mosi
);

   localparam int unsigned c_half  = lamp_half_period(c_freq, c_dck_freq);
   localparam int unsigned c_div_w = $clog2(2 * c_half + 1);
   localparam int unsigned c_cnt_w = $clog2(c_bits + 1);

   localparam logic [c_div_w-1:0] c_half_cnt = c_div_w'(c_half);
   localparam logic [c_div_w-1:0] c_dbl_cnt  = c_div_w'(2 * c_half);
   localparam logic [c_cnt_w-1:0] c_bits_cnt = c_cnt_w'(c_bits);

   lamp_state_t         state_q, state_d;
   logic [c_bits-1:0]   shreg_q, shreg_d;
   logic [c_cnt_w-1:0]  count_q, count_d;
   logic                cs_q, cs_d;
   logic                dck_q, dck_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;

   logic                w_tick;
   logic                w_div_load;
   logic [c_div_w-1:0]  w_div_count;

   // Every state change restarts the divider with the new state's duration.
   assign w_div_load  = (state_d != state_q);
   assign w_div_count = ((state_d == ST_LOW) || (state_d == ST_HIGH)) ? c_half_cnt : c_dbl_cnt;

   dck_divider #(
      .c_width (c_div_w)
   ) u_dck_divider (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_div_load),
      .i_count (w_div_count),
      .o_tick  (w_tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               shreg_d = i_data;
               count_d = c_bits_cnt;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (w_tick) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (w_tick) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (w_tick) begin
               if (count_q != '0) count_d = count_q - c_cnt_w'(1);
               shreg_d = shreg_q << 1;
               state_d = (count_d == '0) ? ST_HOLD : ST_LOW;
            end
         end
         ST_HOLD: begin
            if (w_tick) begin
               state_d = ST_GAP;
               done_d  = 1'b1;
            end
         end
         ST_GAP: begin
            if (w_tick) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // CS and ready follow the next state; DCK and MOSI trail the state by one cycle.
      cs_d    = (state_d == ST_IDLE) || (state_d == ST_GAP);
      ready_d = (state_d == ST_IDLE);
      dck_d   = (state_q == ST_HIGH);
      mosi_d  = ((state_q == ST_LOW) || (state_q == ST_HIGH)) && shreg_q[c_bits-1];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         count_q <= '0;
         cs_q    <= 1'b1;
         dck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
         cs_q    <= cs_d;
         dck_q   <= dck_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_done  = done_q;
   assign o_cs    = cs_q;
   assign o_dck   = dck_q;
   assign o_mosi  = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_tx
// Description : Directed self-checking bench with a loopback lamp receiver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_tx;

   localparam logic [127:0] c_f1 = 128'h000e0078001001001001800800800800;
   localparam logic [127:0] c_f2 = 128'h0123456789abcdeffedcba9876543210;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] data = '0;
   logic         valid = 1'b0;
   logic         ready, done, cs, dck, mosi;

   logic [7:0]   s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready, s_done, s_cs, s_dck, s_mosi;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_frame_tx u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (ready),
      .o_done  (done),
      .o_cs    (cs),
      .o_dck   (dck),
      .o_mosi  (mosi)
   );

   spi_frame_tx #(
      .c_freq     (4),
      .c_dck_freq (1),
      .c_bits     (8)
   ) u_dut_small (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (s_data),
      .i_valid (s_valid),
      .o_ready (s_ready),
      .o_done  (s_done),
      .o_cs    (s_cs),
      .o_dck   (s_dck),
      .o_mosi  (s_mosi)
   );

   // Lamp receiver model plus per-frame timing records for the default instance.
   int           cyc = 0;
   logic         p_cs = 1'b1, p_dck = 1'b0, p_done = 1'b0, p_mosi = 1'b0;
   int           rise_total = 0, done_pulses = 0, done_cycles = 0, nfr = 0, rx_latched = 0;
   int           fall_cyc = 0, last_cs_rise = 0, dck_rise_cyc = 0;
   int           first_rise = -1, rises = 0, badhigh = 0, unstable = 0, rx_bits = 0;
   logic [127:0] rx_sh = '0;
   int           fr_len[16], fr_first[16], fr_rises[16], fr_bad[16], fr_unst[16], fr_bits[16], fr_gap[16];
   logic [127:0] fr_data[16];

   always @(negedge clk) begin
      cyc++;
      if (p_cs && !cs) begin
         fall_cyc = cyc; first_rise = -1; rises = 0; badhigh = 0; unstable = 0; rx_bits = 0;
      end
      if (!p_dck && dck) begin
         rise_total++;
         dck_rise_cyc = cyc;
         if (!cs) begin
            if (rises == 0) first_rise = cyc - fall_cyc;
            rises++;
            if (mosi !== p_mosi) unstable++;
            rx_sh = {rx_sh[126:0], mosi};
            rx_bits++;
         end
      end
      if (p_dck && !dck && (cyc - dck_rise_cyc != 100)) badhigh++;
      if (!p_cs && cs) begin
         if (nfr < 16) begin
            fr_len[nfr] = cyc - fall_cyc;  fr_first[nfr] = first_rise;
            fr_rises[nfr] = rises;         fr_bad[nfr] = badhigh;
            fr_unst[nfr] = unstable;       fr_bits[nfr] = rx_bits;
            fr_data[nfr] = rx_sh;          fr_gap[nfr] = fall_cyc - last_cs_rise;
         end
         nfr++;
         if (rx_bits == 128) rx_latched++;
         last_cs_rise = cyc;
      end
      if (done && !p_done) done_pulses++;
      if (done) done_cycles++;
      p_cs = cs; p_dck = dck; p_done = done; p_mosi = mosi;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs got=%b exp=1", cs); end
      checks++; if (dck !== 1'b0) begin errors++; $display("FAIL reset_dck got=%b exp=0", dck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (s_cs !== 1'b1 || s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_small cs=%b ready=%b exp=1,1", s_cs, s_ready);
      end
      rst = 1'b0;
      tick();
      checks++; if (ready !== 1'b1 || cs !== 1'b1) begin
         errors++; $display("FAIL idle_after_reset ready=%b cs=%b exp=1,1", ready, cs);
      end
   endtask

   task automatic test_reset_priority();
      data = c_f1; valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; valid = 1'b0;
      checks++; if (cs !== 1'b1 || ready !== 1'b1) begin
         errors++; $display("FAIL rst_vs_valid cs=%b ready=%b exp=1,1", cs, ready);
      end
      repeat (5) tick();
      checks++; if (cs !== 1'b1 || dck !== 1'b0) begin
         errors++; $display("FAIL rst_vs_valid_later cs=%b dck=%b exp=1,0", cs, dck);
      end
   endtask

   task automatic test_small_frame();
      logic [7:0] got;
      int low, nr, dn;
      logic pd;
      got = '0; low = 0; nr = 0; dn = 0; pd = 1'b0;
      s_data = 8'hA5; s_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         s_valid = 1'b0;
         if (!s_cs) low++;
         if (s_dck && !pd) begin got = {got[6:0], s_mosi}; nr++; end
         if (s_done) dn++;
         pd = s_dck;
      end
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL small_mosi got=%h exp=a5", got); end
      checks++; if (nr != 8) begin errors++; $display("FAIL small_rises got=%0d exp=8", nr); end
      checks++; if (low != 40) begin errors++; $display("FAIL small_cs_low got=%0d exp=40", low); end
      checks++; if (dn != 1) begin errors++; $display("FAIL small_done got=%0d exp=1", dn); end
   endtask

   task automatic test_back_to_back();
      int  b_fr, b_dn, b_dc, b_rise, n, hit_at;
      bit  hit;
      b_fr = nfr; b_dn = done_pulses; b_dc = done_cycles;
      data = c_f1; valid = 1'b1;
      n = 0;
      while (cs !== 1'b0 && n < 10) begin tick(); n++; end
      checks++; if (cs !== 1'b0) begin errors++; $display("FAIL b2b_accept cs=%b exp=0", cs); end
      data = c_f2; b_rise = rise_total; hit = 1'b0; hit_at = 0; n = 0;
      // Corrupt i_data while bit 40 is high; the in-flight frame must not notice.
      while (ready !== 1'b1 && n < 30000) begin
         tick(); n++;
         if (!hit && (rise_total - b_rise >= 40)) begin data = '1; hit = 1'b1; hit_at = n; end
         if (hit && n == hit_at + 50) data = c_f2;
      end
      checks++; if (n != 26200) begin errors++; $display("FAIL ready_low_len got=%0d exp=26200", n); end
      n = 0;
      while (nfr < b_fr + 2 && n < 30000) begin tick(); n++; end
      valid = 1'b0;
      checks++; if (nfr < b_fr + 2 || b_fr + 1 >= 16) begin
         errors++; $display("FAIL b2b_frames got=%0d exp=%0d", nfr - b_fr, 2);
      end else begin
         checks++; if (fr_data[b_fr] !== c_f1) begin errors++; $display("FAIL frame1_data got=%h exp=%h", fr_data[b_fr], c_f1); end
         checks++; if (fr_bits[b_fr] != 128) begin errors++; $display("FAIL frame1_bits got=%0d exp=128", fr_bits[b_fr]); end
         checks++; if (fr_len[b_fr] != 26000) begin errors++; $display("FAIL frame1_cs_low got=%0d exp=26000", fr_len[b_fr]); end
         checks++; if (fr_first[b_fr] != 301) begin errors++; $display("FAIL cs_to_dck got=%0d exp=301", fr_first[b_fr]); end
         checks++; if (fr_rises[b_fr] != 128) begin errors++; $display("FAIL dck_rises got=%0d exp=128", fr_rises[b_fr]); end
         checks++; if (fr_bad[b_fr] != 0) begin errors++; $display("FAIL dck_high_width bad=%0d exp=0", fr_bad[b_fr]); end
         checks++; if (fr_unst[b_fr] != 0) begin errors++; $display("FAIL mosi_stable bad=%0d exp=0", fr_unst[b_fr]); end
         checks++; if (fr_data[b_fr+1] !== c_f2) begin errors++; $display("FAIL frame2_data got=%h exp=%h", fr_data[b_fr+1], c_f2); end
         checks++; if (fr_gap[b_fr+1] != 201) begin errors++; $display("FAIL cs_high_gap got=%0d exp=201", fr_gap[b_fr+1]); end
         checks++; if (fr_len[b_fr+1] != 26000) begin errors++; $display("FAIL frame2_cs_low got=%0d exp=26000", fr_len[b_fr+1]); end
      end
      checks++; if (done_pulses - b_dn != 2 || done_cycles - b_dc != 2) begin
         errors++; $display("FAIL b2b_done pulses=%0d cycles=%0d exp=2,2", done_pulses - b_dn, done_cycles - b_dc);
      end
      repeat (300) tick();
   endtask

   task automatic test_reset_mid_frame();
      int b_dn, b_rx, b_rise, n;
      b_dn = done_pulses; b_rx = rx_latched;
      data = c_f2; valid = 1'b1;
      n = 0;
      while (cs !== 1'b0 && n < 10) begin tick(); n++; end
      valid = 1'b0;
      b_rise = rise_total; n = 0;
      while (rise_total - b_rise < 64 && n < 20000) begin tick(); n++; end
      checks++; if (rise_total - b_rise < 64) begin errors++; $display("FAIL mid_reach_bit64 got=%0d exp=64", rise_total - b_rise); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({cs, dck, mosi, ready, done} !== 5'b10010) begin
         errors++; $display("FAIL mid_reset_outputs got cs,dck,mosi,ready,done=%b exp=10010", {cs, dck, mosi, ready, done});
      end
      repeat (500) tick();
      checks++; if (done_pulses != b_dn) begin errors++; $display("FAIL mid_reset_done got=%0d exp=0", done_pulses - b_dn); end
      checks++; if (rx_latched != b_rx) begin errors++; $display("FAIL mid_reset_rx got=%0d exp=0", rx_latched - b_rx); end
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL mid_reset_idle cs=%b exp=1", cs); end
   endtask

   initial begin
      test_reset();
      test_reset_priority();
      test_small_frame();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_frame_tx.md
SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 The block SHALL have parameter c_freq, default 20000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter c_dck_freq, default 100000, serial clock frequency in Hz.
REQ-003 The block SHALL have parameter c_bits, default 128, frame length in bits.
REQ-004 Port i_clk  input  1  system clock; all logic is on its rising edge.
REQ-005 Port i_rst  input  1  reset; synchronous, active-high.
REQ-006 Port i_data  input  c_bits  frame to send, MSB first.
REQ-007 Port i_valid  input  1  frame request.
REQ-008 Port o_ready  output  1  block idle; a frame is accepted on i_valid && o_ready.
REQ-009 Port o_done  output  1  one-cycle pulse when a frame completes.
REQ-010 Port o_cs  output  1  chip select, active-low.
REQ-011 Port o_dck  output  1  serial clock, idle low; the receiver samples on the rising edge.
REQ-012 Port o_mosi  output  1  serial data.

Function
REQ-013 Half-period H SHALL be c_freq/(2*c_dck_freq) i_clk cycles, integer division, elaboration-time constant; at defaults H = 100.
REQ-014 The FSM SHALL have the states IDLE, SETUP, LOW, HIGH, HOLD and GAP, with all outputs registered.
REQ-015 IDLE: o_ready=1, o_cs=1, o_dck=0, o_mosi=0; on accept, latch i_data into the shift register, set bit count = c_bits, drive o_cs=0 on the next cycle, enter SETUP.
REQ-016 SETUP SHALL last 2H cycles with o_cs=0, o_dck=0 and o_mosi=0, then enter LOW.
REQ-017 LOW SHALL last H cycles with o_dck=0 and o_mosi = current MSB, stable for the whole state, then enter HIGH.
REQ-018 HIGH SHALL last H cycles with o_dck=1 and o_mosi unchanged. At exit, decrement the count and shift left; if count reaches 0, enter HOLD, otherwise enter LOW.
REQ-019 HOLD SHALL last 2H cycles with o_dck=0, o_mosi=0 and o_cs=0; at exit, drive o_cs=1 and pulse o_done for exactly one cycle.
REQ-020 GAP SHALL last 2H cycles with o_cs=1 and o_ready=0, then enter IDLE; this guarantees a minimum inter-frame chip-select-high time.
REQ-021 Total o_cs-low time SHALL be 2H + 2H*c_bits + 2H cycles; at defaults, 26000 cycles.
REQ-022 i_valid SHALL be ignored whenever o_ready=0, and i_data SHALL NOT be sampled outside the accept cycle.
REQ-023 i_valid held high continuously SHALL produce back-to-back frames, each separated by GAP followed by one IDLE cycle.
REQ-024 The bit counter SHALL be $clog2(c_bits+1) bits wide and SHALL NOT wrap; the count 0 transition is the only HOLD entry.

Reset
REQ-025 When i_rst=1 at a clock edge, the next state SHALL be IDLE with o_cs=1, o_dck=0, o_mosi=0, o_done=0, o_ready=1, and counters and shift register cleared.
REQ-026 Reset mid-frame SHALL abort the frame with no o_done pulse; o_cs rises on the cycle after the reset edge.
REQ-027 If i_rst and i_valid are both asserted in the same cycle, reset SHALL win and the frame SHALL NOT be accepted.

Structure
REQ-028 Shared package lamp_pkg SHALL hold the FSM state encoding constants and the default frequency constants; the frame width is shared with the lamp receiver.
REQ-029 One sub-module, dck_divider, SHALL be instantiated: a load/terminal-count down-counter producing a one-cycle tick after N cycles.

Verification
REQ-030 Defaults, frame 128'h000e0078001001001001800800800800 -> a lamp receiver in loopback latches the identical 128 bits; o_done pulses once.
REQ-031 Timing check -> o_cs to first o_dck rise is 2H+H+1 = 301 cycles including the register stage; 128 o_dck rising edges; each o_dck high for exactly 100 cycles; o_mosi stable across every rise.
REQ-032 Assert i_valid during HIGH of bit 40 with data 128'hFFFF... -> ignored; the in-flight frame is unchanged, and o_ready stays 0 until GAP ends.
REQ-033 Assert i_rst for one cycle during bit 64 -> next cycle o_cs=1, o_dck=0, o_mosi=0, o_ready=1; no o_done; the receiver latches nothing.
REQ-034 i_valid held high with two distinct frames -> o_cs-high gap between frames is at least 200 cycles; both frames are received intact in order.
REQ-035 c_bits=8 with H=2 (c_freq=4, c_dck_freq=1), data 8'hA5 -> o_mosi sequence is 1,0,1,0,0,1,0,1; o_cs low for 40 cycles.
